// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_pack
//  Description : Final rounding and packing stage of the FADD/FSUB datapath.
//                Takes the normalized sign/exponent/fraction, the GRS bits and
//                the special-case flags. Applies IEEE-754 rounding for the
//                RISC-V rounding mode, detects overflow, underflow and inexact,
//                and produces the packed binary32 result with its fflags.
//                Two-stage valid/ready pipeline. Full throughput is one result
//                per cycle with a latency of two cycles.
//
//  Ports
//    clk, reset                 clock and synchronous active-high reset
//    in_valid / in_ready        input handshake
//    in_sign, in_exp, in_mant   normalized sign, biased exponent, fraction
//    in_grs                     {guard, round, sticky}
//    in_underflow               normalizer exponent wrapped below zero
//    in_nan, in_invalid, in_inf special-case path controls
//    rm                         rounding mode (0 RNE,1 RTZ,2 RDN,3 RUP,4 RMM)
//    out_valid / out_ready      output handshake
//    out_result, out_fflags     packed result and {NV,DZ,OF,UF,NX}
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round_pack #(
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [22:0] in_mant,
    input  logic [2:0]  in_grs,
    input  logic        in_underflow,
    input  logic        in_nan,
    input  logic        in_invalid,
    input  logic        in_inf,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_fflags
);

    localparam logic [2:0]  RM_RNE   = 3'd0;
    localparam logic [2:0]  RM_RTZ   = 3'd1;
    localparam logic [2:0]  RM_RDN   = 3'd2;
    localparam logic [2:0]  RM_RUP   = 3'd3;
    localparam logic [2:0]  RM_RMM   = 3'd4;
    localparam logic [30:0] MAG_INF  = 31'h7F80_0000;
    localparam logic [30:0] MAG_MAX  = 31'h7F7F_FFFF;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic advance;

    // S2 can take a new bundle when it is empty or its result is leaving.
    // S1 can take a new bundle when it is empty or it is moving into S2.
    assign advance  = !s2_valid_q || out_ready;
    assign in_ready = advance || !s1_valid_q;

    // ------------------------------------------------------------------
    // Stage 1: register the bundle and decide the increment
    // ------------------------------------------------------------------
    logic        s1_sign_q,  s1_sign_d;
    logic [7:0]  s1_exp_q,   s1_exp_d;
    logic [22:0] s1_mant_q,  s1_mant_d;
    logic        s1_inex_q,  s1_inex_d;
    logic        s1_inc_q,   s1_inc_d;
    logic        s1_uflw_q,  s1_uflw_d;
    logic        s1_nan_q,   s1_nan_d;
    logic        s1_inv_q,   s1_inv_d;
    logic        s1_inf_q,   s1_inf_d;
    logic [2:0]  s1_rm_q,    s1_rm_d;

    logic in_inexact;
    logic in_inc;

    assign in_inexact = |in_grs;

    always_comb begin
        in_inc = 1'b0;
        case (rm)
            RM_RTZ:  in_inc = 1'b0;
            RM_RDN:  in_inc = in_sign & in_inexact;
            RM_RUP:  in_inc = !in_sign & in_inexact;
            RM_RMM:  in_inc = in_grs[2];
            // RNE, and the reserved encodings 5..7 fall back to RNE
            default: in_inc = in_grs[2] & (in_grs[1] | in_grs[0] | in_mant[0]);
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        s1_inex_d  = s1_inex_q;
        s1_inc_d   = s1_inc_q;
        s1_uflw_d  = s1_uflw_q;
        s1_nan_d   = s1_nan_q;
        s1_inv_d   = s1_inv_q;
        s1_inf_d   = s1_inf_q;
        s1_rm_d    = s1_rm_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_exp_d  = in_exp;
                s1_mant_d = in_mant;
                s1_inex_d = in_inexact;
                s1_inc_d  = in_inc;
                s1_uflw_d = in_underflow;
                s1_nan_d  = in_nan;
                s1_inv_d  = in_invalid;
                s1_inf_d  = in_inf;
                s1_rm_d   = rm;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: apply the increment and pack
    // ------------------------------------------------------------------
    logic [30:0] sum;
    logic        ovf;
    logic        uf;
    logic [30:0] ovf_mag;
    logic [31:0] pack_result;
    logic [4:0]  pack_fflags;
    logic [31:0] out_result_q, out_result_d;
    logic [4:0]  out_fflags_q, out_fflags_d;

    // Adding across the whole {exp, frac} field lets a fraction carry ripple
    // into the exponent: subnormal all-ones becomes exp=1, frac all-ones
    // bumps the exponent. An input exponent of FF is caught by ovf directly,
    // so the dropped carry out of bit 30 never matters.
    assign sum = {s1_exp_q, s1_mant_q} + 31'(s1_inc_q);
    assign ovf = (sum[30:23] == 8'hFF) || (s1_exp_q == 8'hFF);
    assign uf  = ((s1_exp_q == 8'h00) && s1_inex_q) || s1_uflw_q;

    // Overflow magnitude: directed modes saturate to max-finite when the
    // rounding direction points toward zero for this sign.
    always_comb begin
        ovf_mag = MAG_INF;
        case (s1_rm_q)
            RM_RTZ:  ovf_mag = MAG_MAX;
            RM_RDN:  ovf_mag = s1_sign_q ? MAG_INF : MAG_MAX;
            RM_RUP:  ovf_mag = s1_sign_q ? MAG_MAX : MAG_INF;
            default: ovf_mag = MAG_INF;
        endcase
    end

    always_comb begin
        pack_result = {s1_sign_q, sum};
        pack_fflags = {3'b000, uf, s1_inex_q};
        if (s1_nan_q) begin
            pack_result = CANON_NAN;
            pack_fflags = {s1_inv_q, 4'b0000};
        end else if (s1_inf_q) begin
            pack_result = {s1_sign_q, MAG_INF};
            pack_fflags = 5'b00000;
        end else if (s1_uflw_q) begin
            pack_result = {s1_sign_q, 31'd0};
            pack_fflags = 5'b00011;
        end else if (ovf) begin
            pack_result = {s1_sign_q, ovf_mag};
            pack_fflags = {2'b00, 1'b1, uf, 1'b1};
        end
    end

    always_comb begin
        s2_valid_d   = s2_valid_q;
        out_result_d = out_result_q;
        out_fflags_d = out_fflags_q;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = pack_result;
                out_fflags_d = pack_fflags;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= 8'd0;
            s1_mant_q    <= 23'd0;
            s1_inex_q    <= 1'b0;
            s1_inc_q     <= 1'b0;
            s1_uflw_q    <= 1'b0;
            s1_nan_q     <= 1'b0;
            s1_inv_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_rm_q      <= 3'd0;
            out_result_q <= 32'd0;
            out_fflags_q <= 5'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_mant_q    <= s1_mant_d;
            s1_inex_q    <= s1_inex_d;
            s1_inc_q     <= s1_inc_d;
            s1_uflw_q    <= s1_uflw_d;
            s1_nan_q     <= s1_nan_d;
            s1_inv_q     <= s1_inv_d;
            s1_inf_q     <= s1_inf_d;
            s1_rm_q      <= s1_rm_d;
            out_result_q <= out_result_d;
            out_fflags_q <= out_fflags_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = out_result_q;
    assign out_fflags = out_fflags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_round_pack
//  Description : Self-checking bench for fp_round_pack. Directed vector table
//                for the rounding/packing function plus hand-written
//                sequences for back-pressure and mid-stream reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_mant;
    logic [2:0]  in_grs;
    logic        in_underflow;
    logic        in_nan;
    logic        in_invalid;
    logic        in_inf;
    logic [2:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_fflags;

    int n_checks = 0;
    int n_fail   = 0;

    fp_round_pack #(.CANON_NAN(32'h7FC0_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .in_grs       (in_grs),
        .in_underflow (in_underflow),
        .in_nan       (in_nan),
        .in_invalid   (in_invalid),
        .in_inf       (in_inf),
        .rm           (rm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_fflags   (out_fflags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic [2:0]  grs;
        logic        uf;
        logic        nan;
        logic        inv;
        logic        inf;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  flags;
        string       name;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(string name, logic s, logic [7:0] e, logic [22:0] m,
                                logic [2:0] g, logic u, logic n, logic iv, logic f,
                                logic [2:0] r, logic [31:0] res, logic [4:0] fl);
        vec_t v;
        v.name = name; v.sign = s; v.exp = e; v.mant = m; v.grs = g;
        v.uf = u; v.nan = n; v.inv = iv; v.inf = f; v.rm = r;
        v.res = res; v.flags = fl;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mant = 23'd0;
        in_grs = 3'd0; in_underflow = 1'b0; in_nan = 1'b0; in_invalid = 1'b0;
        in_inf = 1'b0; rm = 3'd0;
    endtask

    task automatic apply_vec(input vec_t v);
        bit seen;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        in_sign = v.sign; in_exp = v.exp; in_mant = v.mant; in_grs = v.grs;
        in_underflow = v.uf; in_nan = v.nan; in_invalid = v.inv; in_inf = v.inf;
        rm = v.rm;
        @(negedge clk);
        drive_idle();
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            check({v.name, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({v.name, " result"}, out_result, v.res);
            check({v.name, " fflags"}, 32'(out_fflags), 32'(v.flags));
        end
    endtask

    function automatic logic [31:0] flow_res(int i);
        return {1'b0, 8'(8'h80 + i), 23'(i * 3 + 1)};
    endfunction

    initial begin
        int    sent;
        int    got;
        bit    stalled_prev;
        logic [31:0] held;

        //        name          s  exp    mant       grs   uf nan inv inf rm    result        flags
        vecs[0]  = mk("rne_tie_even", 0, 8'h7F, 23'h000000, 3'b100, 0,0,0,0, 3'd0, 32'h3F800000, 5'b00001);
        vecs[1]  = mk("rne_tie_odd",  0, 8'h7F, 23'h000001, 3'b100, 0,0,0,0, 3'd0, 32'h3F800002, 5'b00001);
        vecs[2]  = mk("carry",        0, 8'h7F, 23'h7FFFFF, 3'b110, 0,0,0,0, 3'd0, 32'h40000000, 5'b00001);
        vecs[3]  = mk("ovf_rne",      1, 8'hFE, 23'h7FFFFF, 3'b100, 0,0,0,0, 3'd0, 32'hFF800000, 5'b00101);
        vecs[4]  = mk("ovf_rtz",      1, 8'hFE, 23'h7FFFFF, 3'b100, 0,0,0,0, 3'd1, 32'hFF7FFFFF, 5'b00001);
        vecs[5]  = mk("ovf_rup_neg",  1, 8'hFE, 23'h7FFFFF, 3'b100, 0,0,0,0, 3'd3, 32'hFF7FFFFF, 5'b00001);
        vecs[6]  = mk("ovf_rdn_neg",  1, 8'hFE, 23'h7FFFFF, 3'b100, 0,0,0,0, 3'd2, 32'hFF800000, 5'b00101);
        vecs[7]  = mk("ovf_rup_pos",  0, 8'hFE, 23'h7FFFFF, 3'b001, 0,0,0,0, 3'd3, 32'h7F800000, 5'b00101);
        vecs[8]  = mk("subn_round",   0, 8'h00, 23'h7FFFFF, 3'b100, 0,0,0,0, 3'd0, 32'h00800000, 5'b00011);
        vecs[9]  = mk("subn_exact",   0, 8'h00, 23'h7FFFFF, 3'b000, 0,0,0,0, 3'd0, 32'h007FFFFF, 5'b00000);
        vecs[10] = mk("neg_zero",     1, 8'h00, 23'h000000, 3'b000, 0,0,0,0, 3'd0, 32'h80000000, 5'b00000);
        vecs[11] = mk("nan_invalid",  0, 8'h12, 23'h000055, 3'b111, 0,1,1,0, 3'd0, 32'h7FC00000, 5'b10000);
        vecs[12] = mk("nan_quiet",    1, 8'hFF, 23'h000000, 3'b000, 1,1,0,1, 3'd0, 32'h7FC00000, 5'b00000);
        vecs[13] = mk("inf_exact",    1, 8'h33, 23'h000777, 3'b111, 1,0,0,1, 3'd0, 32'hFF800000, 5'b00000);
        vecs[14] = mk("underflow",    1, 8'h03, 23'h000010, 3'b001, 1,0,0,0, 3'd0, 32'h80000000, 5'b00011);
        vecs[15] = mk("rmm_tie",      0, 8'h7F, 23'h000000, 3'b100, 0,0,0,0, 3'd4, 32'h3F800001, 5'b00001);
        vecs[16] = mk("rdn_pos",      0, 8'h80, 23'h000000, 3'b001, 0,0,0,0, 3'd2, 32'h40000000, 5'b00001);
        vecs[17] = mk("exp_ff_rtz",   0, 8'hFF, 23'h000000, 3'b000, 0,0,0,0, 3'd1, 32'h7F7FFFFF, 5'b00101);

        drive_idle();
        out_ready = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset out_valid",  32'(out_valid), 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_fflags", 32'(out_fflags), 32'd0);
        check("reset in_ready",   32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) apply_vec(vecs[i]);

        // Reserved rounding mode 7 must behave as RNE (tie, odd lsb rounds up)
        begin
            vec_t v;
            v = mk("rm7_as_rne", 0, 8'h7F, 23'h000001, 3'b100, 0,0,0,0, 3'd7, 32'h3F800002, 5'b00001);
            apply_vec(v);
        end

        // Back-to-back stream with out_ready low in cycles 3..5
        repeat (3) @(negedge clk);
        sent = 0; got = 0; stalled_prev = 1'b0; held = 32'd0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_sign  = 1'b0;
                in_exp   = 8'(8'h80 + sent);
                in_mant  = 23'(sent * 3 + 1);
                in_grs   = 3'b000;
                rm       = 3'd0;
            end else begin
                drive_idle();
            end
            #1;
            check("flow in_ready", 32'(in_ready),
                  32'(!((sent - got) == 2 && !out_ready)));
            if (stalled_prev) begin
                check("flow hold valid",  32'(out_valid), 32'd1);
                check("flow hold result", out_result, held);
            end
            if (out_valid && out_ready) begin
                if (got < 8) begin
                    check("flow order", out_result, flow_res(got));
                    check("flow fflags", 32'(out_fflags), 32'd0);
                end else begin
                    check("flow duplicate", 32'd1, 32'd0);
                end
                got++;
            end
            stalled_prev = out_valid && !out_ready;
            held = out_result;
            if (in_valid && in_ready) sent++;
        end
        check("flow delivered", 32'(got), 32'd8);

        // Reset asserted while bundles are in flight
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_exp   = 8'(8'h90 + i);
            in_mant  = 23'(i);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset out_valid",  32'(out_valid), 32'd0);
        check("midreset out_result", out_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        #1;
        check("midreset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("midreset drained", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("midreset no ghost", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
